// File: rtl/axis_operand_splitter_pkg.sv
// Shared constants for the operand splitter and its sibling adder-side benches.
package axis_operand_splitter_pkg;

  localparam int unsigned DefaultW     = 8;
  localparam int unsigned DefaultDepth = 2;

endpackage

// File: rtl/axis_operand_splitter_if.sv
// Stream bundle for the splitter: one 2*W-bit slave input, two W-bit master outputs.
interface axis_operand_splitter_if
  import axis_operand_splitter_pkg::*;
#(
  parameter int unsigned W = DefaultW
);

  logic [2*W-1:0] s_axis_data;
  logic           s_axis_valid;
  logic           s_axis_ready;
  logic [W-1:0]   m_axis_data1;
  logic           m_axis_valid1;
  logic           m_axis_ready1;
  logic [W-1:0]   m_axis_data2;
  logic           m_axis_valid2;
  logic           m_axis_ready2;

  // Environment view: produces input words, consumes both lanes.
  modport master (
    output s_axis_data, s_axis_valid, m_axis_ready1, m_axis_ready2,
    input  s_axis_ready, m_axis_data1, m_axis_valid1, m_axis_data2, m_axis_valid2
  );

  // Splitter view.
  modport slave (
    input  s_axis_data, s_axis_valid, m_axis_ready1, m_axis_ready2,
    output s_axis_ready, m_axis_data1, m_axis_valid1, m_axis_data2, m_axis_valid2
  );

endinterface

// File: rtl/axis_lane_fifo.sv
// Per-lane synchronous FIFO; full/empty come from the occupancy count, not pointer compare.
module axis_lane_fifo
  import axis_operand_splitter_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so the lane presents zero data straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axis_operand_splitter.sv
// AXI-Stream fork: splits a packed operand pair into two independently stalled lanes.
module axis_operand_splitter
  import axis_operand_splitter_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input logic                    clk,
  input logic                    rst,
  axis_operand_splitter_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic            push, pop1, pop2;
  logic            full1, full2, empty1, empty2;
  logic [CntW-1:0] count1, count2;
  logic            unused_count;

  // Ready looks only at registered occupancy, so a same-cycle pop earns no credit.
  assign bus.s_axis_ready  = !full1 && !full2;
  assign push              = bus.s_axis_valid && bus.s_axis_ready;
  assign bus.m_axis_valid1 = !empty1;
  assign bus.m_axis_valid2 = !empty2;
  assign pop1              = bus.m_axis_valid1 && bus.m_axis_ready1;
  assign pop2              = bus.m_axis_valid2 && bus.m_axis_ready2;
  assign unused_count      = ^{count1, count2};

  axis_lane_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_lane1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.s_axis_data[W-1:0]),
    .pop   (pop1),
    .rdata (bus.m_axis_data1),
    .count (count1),
    .full  (full1),
    .empty (empty1)
  );

  axis_lane_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_lane2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.s_axis_data[2*W-1:W]),
    .pop   (pop2),
    .rdata (bus.m_axis_data2),
    .count (count2),
    .full  (full2),
    .empty (empty2)
  );

endmodule

// File: tb/tb_axis_operand_splitter.sv
// Scoreboard bench: accepted words queue their halves; a negedge monitor checks both lanes.
module tb_axis_operand_splitter;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axis_operand_splitter_if #(.W(W)) bus ();

  axis_operand_splitter #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops1  = 0;
  int pops2  = 0;
  bit rand_done;
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a lane holds exactly the halves accepted and not yet consumed.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      check("s_axis_ready", 32'(bus.s_axis_ready),
            32'(q1.size() < int'(DEPTH) && q2.size() < int'(DEPTH)));
      check("m_axis_valid1", 32'(bus.m_axis_valid1), 32'(q1.size() != 0));
      check("m_axis_valid2", 32'(bus.m_axis_valid2), 32'(q2.size() != 0));
      if (bus.m_axis_valid1 && bus.m_axis_ready1) begin
        pops1++;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane1 pop: got %0h, expected no word", bus.m_axis_data1);
        end else check("lane1 data", 32'(bus.m_axis_data1), 32'(q1.pop_front()));
      end
      if (bus.m_axis_valid2 && bus.m_axis_ready2) begin
        pops2++;
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane2 pop: got %0h, expected no word", bus.m_axis_data2);
        end else check("lane2 data", 32'(bus.m_axis_data2), 32'(q2.pop_front()));
      end
      if (bus.s_axis_valid && bus.s_axis_ready) begin
        pushes++;
        q1.push_back(bus.s_axis_data[W-1:0]);
        q2.push_back(bus.s_axis_data[2*W-1:W]);
      end
    end
  end

  task automatic send(input logic [2*W-1:0] word, input int budget);
    bit hs = 1'b0;
    bus.s_axis_data  = word;
    bus.s_axis_valid = 1'b1;
    for (int n = 0; n < budget && !hs; n++) begin
      @(negedge clk);
      hs = bus.s_axis_ready;
      @(posedge clk);
      #1;
    end
    bus.s_axis_valid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL send timeout: word %0h accepted=0, required=1", word);
    end
  endtask

  task automatic drain();
    bus.m_axis_ready1 = 1'b1;
    bus.m_axis_ready2 = 1'b1;
    for (int n = 0; n < 100 && (q1.size() != 0 || q2.size() != 0); n++) begin
      @(posedge clk);
      #1;
    end
    check("drain lane1 empty", 32'(q1.size()), 32'd0);
    check("drain lane2 empty", 32'(q2.size()), 32'd0);
  endtask

  initial begin
    bus.s_axis_data   = '0;
    bus.s_axis_valid  = 1'b0;
    bus.m_axis_ready1 = 1'b0;
    bus.m_axis_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset s_axis_ready", 32'(bus.s_axis_ready), 32'd1);
    check("reset valid1", 32'(bus.m_axis_valid1), 32'd0);
    check("reset valid2", 32'(bus.m_axis_valid2), 32'd0);
    check("reset data1", 32'(bus.m_axis_data1), 32'd0);
    check("reset data2", 32'(bus.m_axis_data2), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word, both consumers ready.
    bus.m_axis_ready1 = 1'b1;
    bus.m_axis_ready2 = 1'b1;
    send(16'h3A15, 20);
    @(negedge clk);
    check("single data1", 32'(bus.m_axis_data1), 32'h15);
    check("single data2", 32'(bus.m_axis_data2), 32'h3A);
    drain();

    // Two words buffered, then an asynchronous mid-cycle reset.
    bus.m_axis_ready1 = 1'b0;
    bus.m_axis_ready2 = 1'b0;
    send(16'h1111, 20);
    send(16'h2222, 20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst valid1", 32'(bus.m_axis_valid1), 32'd0);
    check("async rst valid2", 32'(bus.m_axis_valid2), 32'd0);
    check("async rst ready", 32'(bus.s_axis_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Lane 2 stalled while lane 1 drains.
    bus.m_axis_ready1 = 1'b1;
    bus.m_axis_ready2 = 1'b0;
    send(16'h0201, 20);
    send(16'h0403, 20);
    @(negedge clk);
    check("stall ready low", 32'(bus.s_axis_ready), 32'd0);
    fork
      send(16'h0605, 50);
      begin
        repeat (4) @(posedge clk);
        #1 bus.m_axis_ready2 = 1'b1;
      end
    join
    drain();

    // Full boundary: both lanes pop in the cycle a word is offered.
    bus.m_axis_ready1 = 1'b0;
    bus.m_axis_ready2 = 1'b0;
    send(16'h0B0A, 20);
    send(16'h0D0C, 20);
    bus.s_axis_data   = 16'h0F0E;
    bus.s_axis_valid  = 1'b1;
    bus.m_axis_ready1 = 1'b1;
    bus.m_axis_ready2 = 1'b1;
    @(negedge clk);
    check("full no push", 32'(bus.s_axis_ready), 32'd0);
    @(posedge clk);
    #1 bus.m_axis_ready1 = 1'b0;
    bus.m_axis_ready2 = 1'b0;
    @(negedge clk);
    check("full push next cycle", 32'(bus.s_axis_ready), 32'd1);
    @(posedge clk);
    #1 bus.s_axis_valid = 1'b0;
    drain();

    // Back-to-back throughput across pointer wrap.
    bus.s_axis_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.s_axis_data = {8'(i), 8'(i)};
      @(negedge clk);
      check("streaming ready", 32'(bus.s_axis_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.s_axis_valid = 1'b0;
    drain();

    // Random throttling on all three interfaces.
    pops1 = 0;
    pops2 = 0;
    pushes = 0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(16'($urandom), 1000);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.m_axis_ready1 = ($urandom_range(0, 3) != 0);
          bus.m_axis_ready2 = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    check("random pushes", 32'(pushes), 32'd1000);
    check("random lane1 count", 32'(pops1), 32'd1000);
    check("random lane2 count", 32'(pops2), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
